// File: rtl/csa_stream_accumulator.sv
// ---------------------------------------------------------------------------
// csa_stream_accumulator
//
// Streaming multi-operand adder. A frame of unsigned N-bit operands arrives
// LANES operands per beat and is accumulated in redundant carry-save form
// (sum_q + carry_q). Each beat runs only through a chain of 3:2 compressors,
// so no carry-propagate adder sits on the per-beat path. One carry-propagate
// add is done in the RES state once the frame has closed.
//
// Optional feature macro: CSA_STREAM_SIGNED_EN
//   defined   : lanes are two's-complement and are sign-extended to SUM_W
//   undefined : lanes are zero-extended (unsigned)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   beat valid
//   in_ready   beat accepted when in_valid && in_ready (IDLE/ACC only)
//   in_data    LANES operands; lane k = in_data[k*N +: N]
//   in_keep    per-lane enable; a disabled lane contributes zero
//   in_last    final beat of the frame
//   out_valid  result valid (held until out_ready)
//   out_ready  result consumed when out_valid && out_ready
//   out_sum    frame sum mod 2^SUM_W
//   out_count  operands summed, saturating at COUNT_MAX
//   out_ovf    frame carried more than COUNT_MAX operands
// ---------------------------------------------------------------------------
module csa_stream_accumulator #(
    parameter int N         = 8,
    parameter int LANES     = 2,
    parameter int COUNT_MAX = 10,
    localparam int SUM_W    = N + $clog2(COUNT_MAX),
    localparam int CNT_W    = $clog2(COUNT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   in_data,
    input  logic [LANES-1:0]     in_keep,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_W-1:0]     out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);
    // Wide enough for cnt + popcount of up to 8 lanes without wrapping.
    localparam int POP_W = CNT_W + 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RES  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             first_beat;
    logic [SUM_W-1:0] lane_op [LANES];
    logic [SUM_W-1:0] csa_s, csa_c, csa_t;
    logic [POP_W-1:0] pop, cnt_sum;

    assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_ACC);
    assign accept     = in_valid && in_ready;
    // The first beat of a frame compresses against a zero state, so stale
    // sum/carry from the previous frame never needs an explicit clear.
    assign first_beat = (state_q == ST_IDLE);

    // Masked, width-extended lane operands.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [N-1:0] lane_raw;
            assign lane_raw = in_data[gi*N +: N];
`ifdef CSA_STREAM_SIGNED_EN
            assign lane_op[gi] = in_keep[gi] ? {{(SUM_W-N){lane_raw[N-1]}}, lane_raw} : '0;
`else
            assign lane_op[gi] = in_keep[gi] ? {{(SUM_W-N){1'b0}}, lane_raw} : '0;
`endif
        end
    endgenerate

    // 3:2 compressor chain: each lane folds into the redundant pair. The
    // carry vector is kept pre-shifted, so its bit 0 is always zero.
    always_comb begin
        csa_s = first_beat ? '0 : sum_q;
        csa_c = first_beat ? '0 : carry_q;
        csa_t = '0;
        for (int k = 0; k < LANES; k++) begin
            csa_t = csa_s ^ csa_c ^ lane_op[k];
            csa_c = ((csa_s & csa_c) | (csa_s & lane_op[k]) | (csa_c & lane_op[k])) << 1;
            csa_s = csa_t;
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            pop = pop + POP_W'(in_keep[k]);
        end
        cnt_sum = (first_beat ? '0 : POP_W'(cnt_q)) + pop;
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    sum_d   = csa_s;
                    carry_d = csa_c;
                    if (cnt_sum > POP_W'(COUNT_MAX)) begin
                        cnt_d = CNT_W'(COUNT_MAX);
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_sum[CNT_W-1:0];
                        ovf_d = first_beat ? 1'b0 : ovf_q;
                    end
                    state_d = in_last ? ST_RES : ST_ACC;
                end
            end
            ST_RES: begin
                // The only carry-propagate add in the design.
                out_sum_d   = sum_q + carry_q;
                out_count_d = cnt_q;
                out_ovf_d   = ovf_q;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = (state_q == ST_OUT);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_stream_accumulator
//
// Self-checking bench: directed frames followed by random frames. Each
// accepted beat updates a plain-integer reference (running frame sum and raw
// operand count); results are checked against that reference reduced with
// the frame rules (sum mod 2^SUM_W, count saturation, count-based overflow).
// ---------------------------------------------------------------------------
module tb_csa_stream_accumulator;
    localparam int N         = 8;
    localparam int LANES     = 2;
    localparam int COUNT_MAX = 10;
    localparam int SUM_W     = N + $clog2(COUNT_MAX);
    localparam int CNT_W     = $clog2(COUNT_MAX + 1);
    localparam int SUM_MASK  = (1 << SUM_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*N-1:0]   in_data;
    logic [LANES-1:0]     in_keep;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [SUM_W-1:0]     out_sum;
    logic [CNT_W-1:0]     out_count;
    logic                 out_ovf;

    int checks = 0;
    int errors = 0;
    int m_sum  = 0;   // reference frame sum (unbounded integer)
    int m_cnt  = 0;   // reference raw operand count

    csa_stream_accumulator #(.N(N), .LANES(LANES), .COUNT_MAX(COUNT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int lane_val(input logic [N-1:0] v);
`ifdef CSA_STREAM_SIGNED_EN
        return int'($signed(v));
`else
        return int'({24'd0, v});
`endif
    endfunction

    // Present one beat, wait (bounded) for acceptance, update the reference.
    task automatic send_beat(input logic [LANES*N-1:0] d, input logic [LANES-1:0] k,
                             input logic l);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("beat_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (k[i]) begin
                m_sum += lane_val(d[i*N +: N]);
                m_cnt += 1;
            end
        end
        $display("beat data=%h keep=%b last=%b", d, k, l);
    endtask

    // Called at posedge+1 right after the last beat was accepted.
    task automatic get_result(input int stall);
        logic [31:0] exp_sum, exp_cnt, exp_ovf;
        exp_sum = m_sum & SUM_MASK;
        exp_cnt = (m_cnt > COUNT_MAX) ? COUNT_MAX : m_cnt;
        exp_ovf = (m_cnt > COUNT_MAX) ? 1 : 0;
        check_eq("res_cycle_valid", out_valid, 1'b0);
        check_eq("res_cycle_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check_eq("out_valid", out_valid, 1'b1);
        check_eq("out_sum", out_sum, exp_sum);
        check_eq("out_count", out_count, exp_cnt);
        check_eq("out_ovf", out_ovf, exp_ovf);
        for (int s = 0; s < stall; s++) begin
            // A beat offered while the result is pending must be ignored.
            in_valid = 1'b1;
            in_data  = (LANES*N)'($urandom);
            in_keep  = '1;
            in_last  = 1'b1;
            check_eq("stall_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            check_eq("stall_valid", out_valid, 1'b1);
            check_eq("stall_sum", out_sum, exp_sum);
            check_eq("stall_count", out_count, exp_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_hs_valid", out_valid, 1'b0);
        check_eq("post_hs_ready", in_ready, 1'b1);
        $display("result sum=%h count=%0d ovf=%0d stall=%0d", out_sum, out_count, out_ovf, stall);
        m_sum = 0;
        m_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_sum", out_sum, 0);
        check_eq("rst_count", out_count, 0);
        check_eq("rst_ovf", out_ovf, 0);
        rst = 1'b0;

        // Full frame of ten 0xFF operands.
        for (int b = 0; b < 5; b++) send_beat({8'hFF, 8'hFF}, 2'b11, b == 4);
`ifndef CSA_STREAM_SIGNED_EN
        check_eq("full_frame_ref", m_sum, 2550);
`endif
        get_result(0);

        // Single lane, then a fresh frame with no carry-over.
        send_beat({8'd3, 8'd7}, 2'b01, 1'b1);
        get_result(0);
        send_beat({8'd1, 8'd1}, 2'b11, 1'b0);
        send_beat({8'd1, 8'd1}, 2'b11, 1'b1);
        get_result(5);

        // Overflow: twelve operands, then a frame where ovf must be clear.
        for (int b = 0; b < 6; b++) send_beat({8'd1, 8'd1}, 2'b11, b == 5);
        get_result(1);
        send_beat({8'd9, 8'd4}, 2'b11, 1'b1);
        get_result(0);

        // keep=0 beat closes a frame while adding nothing.
        send_beat({8'd20, 8'd30}, 2'b10, 1'b0);
        send_beat({8'hAA, 8'h55}, 2'b00, 1'b1);
        get_result(0);

        // Reset mid-frame discards the frame.
        for (int b = 0; b < 3; b++) send_beat({8'd50, 8'd60}, 2'b11, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        check_eq("midrst_ready", in_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check_eq("midrst_valid", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        send_beat({8'd5, 8'd5}, 2'b11, 1'b1);
        get_result(0);

        // Signed build: two beats of -1,-1.
        send_beat({8'hFF, 8'hFF}, 2'b11, 1'b0);
        send_beat({8'hFF, 8'hFF}, 2'b11, 1'b1);
        get_result(0);

        // Random frames with random gaps, keeps and stalls.
        for (int f = 0; f < 25; f++) begin
            int nb;
            nb = $urandom_range(1, 7);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_beat((LANES*N)'($urandom), LANES'($urandom), b == nb - 1);
            end
            get_result($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
